uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer between the UART `rx` deserializer and the APB register front end in `topp`. It captures each frame the receiver completes (`fifo_wr` pulse), together with its parity and frame error flags, and holds it in a circular FIFO until the APB read path pops it. It also produces the RX-level interrupt request that feeds `interupt_out`.

## Interface
Parameters:
- `DEPTH`, 16: number of entries. Must be a power of two, at least 2.
- `TIMEOUT_TICKS`, 32: count of idle baud ticks before the character-timeout flag sets. Used only when `UART_RX_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset. Asynchronous, active-high.
- `wr_en` in 1: frame-complete pulse from `rx`.
- `wr_data` in 8: received data, right-aligned. Frames of 5–7 bits are zero-padded above the frame size.
- `parity_error` in 1: parity flag for the frame being written.
- `frame_error` in 1: frame (stop-bit) flag for the frame being written.
- `rd_en` in 1: pop request from the APB read decode.
- `rd_data` out 10: head entry, laid out as {`frame_error`, `parity_error`, `data[7:0]`}.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `thresh` in $clog2(DEPTH)+1: interrupt threshold. A value of 0 disables the level interrupt.
- `overrun` out 1: sticky flag, set when a write is dropped.
- `clr_overrun` in 1: clears `overrun`.
- `baud_tick` in 1: one-cycle baud-rate tick. Used only for the timeout.
- `irq` out 1: RX interrupt request.

## Operation
- Storage is circular. `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. `count` is tracked separately.
- `rd_data` is first-word-fall-through: it always shows `mem[rd_ptr]`. It is valid only while `empty`=0 and is don't-care when empty.
- Accepted write: `wr_en` && (!`full` || `rd_en`).
- Accepted read: `rd_en` && !`empty`. A read while empty is ignored and `count` is unchanged.
- Write and read accepted in the same cycle: `count` is unchanged and both pointers advance. This holds when full too, so no overrun occurs.
- Write while full with no read: the entry is dropped, `overrun` is set, and pointers and `count` are unchanged.
- `clr_overrun` and a new overrun in the same cycle: the set wins.
- `empty` = (`count`==0). `full` = (`count`==DEPTH). Both are decoded from registered `count`.
- Level interrupt: `irq_lvl` = (`thresh`!=0) && (`count` >= `thresh`). A `thresh` above DEPTH never fires.
- `irq` = `irq_lvl` | `overrun` | `timeout` (with `timeout` tied to 0 when the feature is compiled out).
- Reset: pointers = 0, `count` = 0, `empty` = 1, `full` = 0, `overrun` = 0, timeout counter and flag = 0, `irq` = 0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored entries immediately, asynchronously.

## Timing
- Write-to-visible latency is 1 cycle. A `wr_en` at edge N gives `rd_data`, `count` and `empty` updated after edge N.
- A pop takes effect at the edge. The next entry appears on `rd_data` in the following cycle.
- `irq` is combinational from registered state, so it changes 1 cycle after the causing write or read.
- `overrun` sets 1 cycle after the dropped write.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - A counter of $clog2(TIMEOUT_TICKS+1) bits increments on `baud_tick` while `empty`=0.
  - The counter clears on any accepted write, any accepted read, or `empty`.
  - When the counter reaches `TIMEOUT_TICKS`, `timeout` sets and the counter saturates.
  - `timeout` clears on the next accepted read or write, or when the FIFO becomes empty.
- `UART_RX_TIMEOUT_EN` undefined:
  - No counter logic is built; `timeout` is constant 0.
  - `baud_tick` and `TIMEOUT_TICKS` are unused.

## Structure
- `uart_pkg` holds:
  - `rx_entry_t` packed struct {`frame_err`, `parity_err`, `data[7:0]`}, 10 bits.
  - `RX_ENTRY_W` = 10.
  - The default depth and timeout constants.
- One sub-module, `uart_fifo_mem`: a DEPTH×`rx_entry_t` register array with a synchronous write port and an asynchronous read port, and no reset.
- Pointer, count, flag and timeout logic live in `uart_rx_fifo`.

## Test plan
- Reset, then write 0xA8 with `parity_error`=1 → next cycle `rd_data`=10'h1A8, `count`=1, `empty`=0. Pop → `empty`=1.
- Write DEPTH entries 0x00..0x0F, one more write of 0x55 → `full`=1 and `overrun`=1. Pop all → reads 0x00..0x0F in order; 0x55 is absent.
- Fill to full, then assert `rd_en`+`wr_en` with 0x3A together → `count` stays 16 and `overrun` stays 0. After 16 pops, the last `rd_data` is 0x03A, which checks wrap-around.
- `thresh`=4: write 3 entries → `irq`=0. Write a 4th → `irq`=1 on the next cycle. One pop → `irq`=0. With `thresh`=0, 16 writes → `irq`=0.
- With `UART_RX_TIMEOUT_EN` and `TIMEOUT_TICKS`=4: write 1 entry, then 4 `baud_tick` pulses → `irq`=1. One pop → `irq`=0. Ticks while empty → `irq` stays 0.
- Assert `rst` asynchronously with 5 entries stored → `count`=0, `empty`=1 and `irq`=0 before the next clock edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive buffer.
package uart_pkg;

    localparam int unsigned RX_ENTRY_W            = 10;
    localparam int unsigned DEFAULT_DEPTH         = 16;
    localparam int unsigned DEFAULT_TIMEOUT_TICKS = 32;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the rx deserializer / APB read decode (master) and the receive FIFO (slave).
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = uart_pkg::DEFAULT_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                            wr_en;
    logic [7:0]                      wr_data;
    logic                            parity_error;
    logic                            frame_error;
    logic                            rd_en;
    logic [uart_pkg::RX_ENTRY_W-1:0] rd_data;
    logic [CW-1:0]                   count;
    logic                            empty;
    logic                            full;
    logic [CW-1:0]                   thresh;
    logic                            overrun;
    logic                            clr_overrun;
    logic                            baud_tick;
    logic                            irq;

    modport master (
        output wr_en, wr_data, parity_error, frame_error, rd_en, thresh, clr_overrun, baud_tick,
        input  rd_data, count, empty, full, overrun, irq
    );

    modport slave (
        input  wr_en, wr_data, parity_error, frame_error, rd_en, thresh, clr_overrun, baud_tick,
        output rd_data, count, empty, full, overrun, irq
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Entry storage for the receive FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  rx_entry_t       wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output rx_entry_t       rdata_o
);

    rx_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with overrun tracking and RX interrupt generation.
// Optional character timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH         = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_fifo_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;

    logic      empty, full;
    logic      wr_ok, rd_ok, wr_drop;
    logic      irq_lvl, timeout;
    rx_entry_t wr_entry, rd_entry;

    assign empty = (count_q == '0);
    assign full  = (count_q == DepthC);

    // A read frees a slot in the same edge, so a write into a full FIFO is fine alongside a pop.
    assign wr_ok   = bus.wr_en && (!full || bus.rd_en);
    assign rd_ok   = bus.rd_en && !empty;
    assign wr_drop = bus.wr_en && full && !bus.rd_en;

    assign wr_entry = '{frame_err: bus.frame_error, parity_err: bus.parity_error,
                        data: bus.wr_data};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_drop) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TimeoutC = TW'(TIMEOUT_TICKS);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        if (wr_ok || rd_ok || empty) begin
            tcnt_d    = '0;
            timeout_d = 1'b0;
        end else if (bus.baud_tick && (tcnt_q != TimeoutC)) begin
            tcnt_d = tcnt_q + TW'(1);
            if (tcnt_d == TimeoutC) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = bus.baud_tick ^ (TIMEOUT_TICKS != 0);
    assign timeout            = 1'b0;
`endif

    // Threshold above DEPTH can never be reached, so it silently disables the level interrupt.
    assign irq_lvl = (bus.thresh != '0) && (count_q >= bus.thresh);

    assign bus.rd_data = rd_entry;
    assign bus.count   = count_q;
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.overrun = overrun_q;
    assign bus.irq     = irq_lvl | overrun_q | timeout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios plus randomized traffic.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TT    = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DEPTH         (DEPTH),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected entries in arrival order plus flag state.
    logic [9:0] sb_q[$];
    int mcnt    = 0;
    bit movr    = 1'b0;
    bit mtout   = 1'b0;
    int mtcnt   = 0;
    int mthresh = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop the DUT performs must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.rd_en === 1'b1 && bus.empty === 1'b0) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got %h expected no entry", bus.rd_data);
            end else begin
                check("rd_data", 32'(bus.rd_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic check_state();
        bit exp_irq;
        exp_irq = (mthresh != 0 && mcnt >= mthresh) || movr || mtout;
        check("count",   32'(bus.count),   32'(mcnt));
        check("empty",   32'(bus.empty),   32'(mcnt == 0));
        check("full",    32'(bus.full),    32'(mcnt == DEPTH));
        check("overrun", 32'(bus.overrun), 32'(movr));
        check("irq",     32'(bus.irq),     32'(exp_irq));
    endtask

    // Called just after a rising edge; drives one cycle, updates the model, checks afterwards.
    task automatic cyc(input bit w, input logic [7:0] d, input bit pe, input bit fe,
                       input bit r, input bit clr = 1'b0, input bit tick = 1'b0);
        bit aw, ar;
        int old;
        bus.wr_en        = w;
        bus.wr_data      = d;
        bus.parity_error = pe;
        bus.frame_error  = fe;
        bus.rd_en        = r;
        bus.clr_overrun  = clr;
        bus.baud_tick    = tick;
        old = mcnt;
        aw  = w && (old < DEPTH || r);
        ar  = r && old > 0;
        if (aw) sb_q.push_back({fe, pe, d});
        mcnt = old + int'(aw) - int'(ar);
        if (w && old == DEPTH && !r) movr = 1'b1;
        else if (clr) movr = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
        if (aw || ar || old == 0) begin
            mtcnt = 0;
            mtout = 1'b0;
        end else if (tick && mtcnt < TT) begin
            mtcnt++;
            if (mtcnt == TT) mtout = 1'b1;
        end
`endif
        @(posedge clk);
        #2;
        check_state();
    endtask

    task automatic set_thresh(input int t);
        mthresh    = t;
        bus.thresh = CW'(t);
    endtask

    task automatic drain();
        while (mcnt > 0) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.wr_en        = 1'b0;
        bus.wr_data      = '0;
        bus.parity_error = 1'b0;
        bus.frame_error  = 1'b0;
        bus.rd_en        = 1'b0;
        bus.clr_overrun  = 1'b0;
        bus.baud_tick    = 1'b0;
        bus.thresh       = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_state();
        rst = 1'b0;

        // Single entry with parity error, then pop.
        cyc(1'b1, 8'hA8, 1'b1, 1'b0, 1'b0);
        check("rd_data_a8", 32'(bus.rd_data), 32'h1A8);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Fill, overflow by one, drain in order.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        drain();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous read and write while full; last pop must return the wrapped entry.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'h3A, 1'b0, 1'b0, 1'b1);
        drain();

        // Level interrupt threshold.
        set_thresh(4);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();
        set_thresh(0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h20 + i), 1'b1, 1'b1, 1'b0);
        drain();

        // Character timeout (no effect when compiled out).
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TT; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < TT + 2; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(31, 0) == 0) set_thresh(int'($urandom_range(DEPTH + 4, 0)));
            cyc(($urandom & 1) != 0, 8'($urandom), ($urandom_range(3, 0) == 0),
                ($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0),
                ($urandom_range(7, 0) == 0), ($urandom_range(1, 0) == 0));
        end

        // Asynchronous reset with entries stored.
        drain();
        set_thresh(2);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr_overrun = 1'b0;
        bus.baud_tick = 1'b0;
        rst = 1'b1;
        #1;
        sb_q.delete();
        mcnt  = 0;
        movr  = 1'b0;
        mtout = 1'b0;
        mtcnt = 0;
        check("rst_count", 32'(bus.count), 32'(0));
        check("rst_empty", 32'(bus.empty), 32'(1));
        check("rst_irq",   32'(bus.irq),   32'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
